// File: rtl/knn_sched_pkg.sv
// knn_sched_pkg: shared types for the KNN run sequencer.
// State encoding and default neighbour-list depth.
package knn_sched_pkg;

  localparam int KNN_K_DEF = 10;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CLR   = 4'd1,
    S_FETCH = 4'd2,
    S_DIST  = 4'd3,
    S_SCAN  = 4'd4,
    S_INS   = 4'd5,
    S_NEXT  = 4'd6,
    S_VOTE  = 4'd7,
    S_VWAIT = 4'd8,
    S_DONE  = 4'd9
  } state_t;

endpackage

// File: rtl/knn_sched_cnt.sv
// knn_cnt: up-counter with clear, increment and last flag.
// limit is one bit wider so a limit of 2^W still fits.
module knn_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W:0]   limit,
  output logic [W-1:0] value,
  output logic         last
);

  // clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || clr)
      value <= '0;
    else if (inc)
      value <= value + 1'b1;
  end

  assign last = ({1'b0, value} == (limit - 1'b1));

endmodule

// File: rtl/knn_sched.sv
// knn_sched: run-level sequencer for the KNN accelerator.
// Walks test x data pairs, scans the neighbour list, votes.
module knn_sched
  import knn_sched_pkg::*;
#(
  parameter int K       = KNN_K_DEF,
  parameter int NDATA_W = 10,
  parameter int NTEST_W = 6,
  parameter int SLOT_W  = $clog2(K)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NDATA_W-1:0] n_data,
  input  logic [NTEST_W-1:0] n_test,
  input  logic               cmp_lt,
  input  logic               vote_done,
  output logic               busy,
  output logic               done,
  output logic               mem_rd,
  output logic [NTEST_W-1:0] test_addr,
  output logic [NDATA_W-1:0] data_addr,
  output logic               en_dist,
  output logic               nb_clr,
  output logic [SLOT_W-1:0]  slot_idx,
  output logic               nb_ins,
  output logic               vote_start
);

  state_t state, state_n;

  logic [NDATA_W-1:0] n_data_q;
  logic [NTEST_W-1:0] n_test_q;

  logic d_clr, d_inc, d_last;
  logic t_clr, t_inc, t_last;
  logic s_clr, s_inc, s_last;

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // counts are captured once per run
  always_ff @(posedge clk) begin
    if (rst) begin
      n_data_q <= '0;
      n_test_q <= '0;
    end else if (state == S_IDLE && start) begin
      n_data_q <= n_data;
      n_test_q <= n_test;
    end
  end

  // next state and counter controls
  always_comb begin
    state_n = state;
    d_clr   = 1'b0;
    d_inc   = 1'b0;
    t_clr   = 1'b0;
    t_inc   = 1'b0;
    s_clr   = 1'b0;
    s_inc   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (n_test == '0) begin
            state_n = S_DONE;
          end else begin
            t_clr   = 1'b1;
            state_n = S_CLR;
          end
        end
      end
      S_CLR: begin
        d_clr   = 1'b1;
        state_n = (n_data_q == '0) ? S_VOTE : S_FETCH;
      end
      S_FETCH: state_n = S_DIST;
      S_DIST: begin
        s_clr   = 1'b1;
        state_n = S_SCAN;
      end
      S_SCAN: begin
        if (cmp_lt)
          state_n = S_INS;
        else if (s_last)
          state_n = S_NEXT;
        else
          s_inc = 1'b1;
      end
      S_INS: state_n = S_NEXT;
      S_NEXT: begin
        if (d_last) begin
          state_n = S_VOTE;
        end else begin
          d_inc   = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_VOTE: state_n = S_VWAIT;
      S_VWAIT: begin
        if (vote_done) begin
          if (t_last) begin
            state_n = S_DONE;
          end else begin
            t_inc   = 1'b1;
            state_n = S_CLR;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  knn_cnt #(.W(NDATA_W)) u_data (
    .clk   (clk),
    .rst   (rst),
    .clr   (d_clr),
    .inc   (d_inc),
    .limit ({1'b0, n_data_q}),
    .value (data_addr),
    .last  (d_last)
  );

  knn_cnt #(.W(NTEST_W)) u_test (
    .clk   (clk),
    .rst   (rst),
    .clr   (t_clr),
    .inc   (t_inc),
    .limit ({1'b0, n_test_q}),
    .value (test_addr),
    .last  (t_last)
  );

  knn_cnt #(.W(SLOT_W)) u_slot (
    .clk   (clk),
    .rst   (rst),
    .clr   (s_clr),
    .inc   (s_inc),
    .limit ((SLOT_W+1)'(K)),
    .value (slot_idx),
    .last  (s_last)
  );

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign mem_rd     = (state == S_FETCH);
  assign en_dist    = (state == S_DIST);
  assign nb_clr     = (state == S_CLR);
  assign nb_ins     = (state == S_INS);
  assign vote_start = (state == S_VOTE);

endmodule

// File: tb/tb_knn_sched.sv
// tb_knn_sched: scoreboard bench for the KNN sequencer.
// Expected strobe events come from a cycle-timing model.
module tb_knn_sched;

  localparam int K  = 4;
  localparam int DW = 10;
  localparam int TW = 6;
  localparam int SW = 2;

  localparam logic [5:0] B_CLR  = 6'b000001;
  localparam logic [5:0] B_RD   = 6'b000010;
  localparam logic [5:0] B_EN   = 6'b000100;
  localparam logic [5:0] B_INS  = 6'b001000;
  localparam logic [5:0] B_VOTE = 6'b010000;
  localparam logic [5:0] B_DONE = 6'b100000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] n_data = '0;
  logic [TW-1:0] n_test = '0;
  logic          cmp_lt;
  logic          vote_done = 1'b0;
  logic          busy, done, mem_rd, en_dist;
  logic          nb_clr, nb_ins, vote_start;
  logic [TW-1:0] test_addr;
  logic [DW-1:0] data_addr;
  logic [SW-1:0] slot_idx;

  int ins_s = -1;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [5:0] stb;
    int         da;
    int         ta;
    int         si;
  } ev_t;

  ev_t exp_q[$];
  int  exp_slot[int];

  knn_sched #(
    .K(K), .NDATA_W(DW), .NTEST_W(TW), .SLOT_W(SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_data     (n_data),
    .n_test     (n_test),
    .cmp_lt     (cmp_lt),
    .vote_done  (vote_done),
    .busy       (busy),
    .done       (done),
    .mem_rd     (mem_rd),
    .test_addr  (test_addr),
    .data_addr  (data_addr),
    .en_dist    (en_dist),
    .nb_clr     (nb_clr),
    .slot_idx   (slot_idx),
    .nb_ins     (nb_ins),
    .vote_start (vote_start)
  );

  always #5 clk = ~clk;

  assign cmp_lt = (ins_s >= 0) && (int'(slot_idx) == ins_s);

  function automatic logic [5:0] strobes();
    return {done, vote_start, nb_ins, en_dist, mem_rd, nb_clr};
  endfunction

  function automatic void push(int c, logic [5:0] s,
                               int da, int ta, int si);
    ev_t e;
    e.cyc = c; e.stb = s; e.da = da; e.ta = ta; e.si = si;
    exp_q.push_back(e);
  endfunction

  // timing model: fills the scoreboard, returns done cycle
  function automatic int gen(int nt, int nd, int ins, int vd);
    int c = 0;
    exp_q.delete();
    exp_slot.delete();
    if (nt == 0) begin
      push(1, B_DONE, -1, -1, -1);
      return 1;
    end
    for (int t = 0; t < nt; t++) begin
      c++;
      push(c, B_CLR, -1, t, -1);
      for (int d = 0; d < nd; d++) begin
        push(c + 1, B_RD, d, t, -1);
        push(c + 2, B_EN, d, t, -1);
        if (ins >= 0 && ins < K) begin
          for (int i = 0; i <= ins; i++) exp_slot[c + 3 + i] = i;
          push(c + 4 + ins, B_INS, d, t, ins);
          c += 5 + ins;
        end else begin
          for (int i = 0; i < K; i++) exp_slot[c + 3 + i] = i;
          c += K + 3;
        end
      end
      c++;
      push(c, B_VOTE, -1, t, -1);
      c += 1 + vd;
    end
    c++;
    push(c, B_DONE, -1, -1, -1);
    return c;
  endfunction

  // drives one run and scores every cycle against the model
  task automatic run(input string nm, input int nt, input int nd,
                     input int ins, input int vd, input bit vtie,
                     input bit hold, output int n_clr,
                     output int n_ins, output int n_vote,
                     output int n_done, output int n_rd);
    int dc, cyc, rem;
    bit pend;
    logic [5:0] s;
    ev_t e;
    dc = gen(nt, nd, ins, vd);
    n_clr = 0; n_ins = 0; n_vote = 0; n_done = 0; n_rd = 0;
    pend = 0; rem = 0; cyc = 0;
    ins_s = ins;
    vote_done = vtie;
    @(negedge clk);
    start = 1'b1;
    n_data = DW'(nd);
    n_test = TW'(nt);
    while (cyc < dc + 2) begin
      @(negedge clk);
      cyc++;
      if (!hold || cyc >= dc) start = 1'b0;
      if (hold && cyc == 1) begin
        n_data = DW'(nd + 3);
        n_test = TW'(nt + 4);
      end
      if (!vtie) begin
        vote_done = 1'b0;
        if (pend) begin
          if (rem == 0) begin
            vote_done = 1'b1;
            pend = 0;
          end else rem--;
        end
        if (vote_start) begin
          pend = 1;
          rem = vd;
        end
      end
      checks++;
      if (busy !== (cyc >= 1 && cyc <= dc)) begin
        errors++;
        $display("FAIL %s busy c%0d got=%b want=%b",
                 nm, cyc, busy, (cyc >= 1 && cyc <= dc));
      end
      if (exp_slot.exists(cyc)) begin
        checks++;
        if (int'(slot_idx) !== exp_slot[cyc]) begin
          errors++;
          $display("FAIL %s slot_idx c%0d got=%0d want=%0d",
                   nm, cyc, slot_idx, exp_slot[cyc]);
        end
      end
      s = strobes();
      n_clr  += int'(nb_clr);
      n_ins  += int'(nb_ins);
      n_vote += int'(vote_start);
      n_done += int'(done);
      n_rd   += int'(mem_rd);
      if (s != '0 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL %s strobe c%0d got=%b want=none",
                   nm, cyc, s);
        end else begin
          e = exp_q.pop_front();
          if (s !== e.stb ||
              (e.da >= 0 && int'(data_addr) != e.da) ||
              (e.ta >= 0 && int'(test_addr) != e.ta) ||
              (e.si >= 0 && int'(slot_idx) != e.si)) begin
            errors++;
            $display("FAIL %s event c%0d got=%b d%0d t%0d s%0d want=%b d%0d t%0d s%0d",
                     nm, cyc, s, data_addr, test_addr, slot_idx,
                     e.stb, e.da, e.ta, e.si);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing got=%0d events left want=0",
               nm, exp_q.size());
    end
    vote_done = 1'b0;
    ins_s = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    n_test = 6'd2;
    n_data = 10'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, strobes(), slot_idx, data_addr, test_addr} !== '0) begin
        errors++;
        $display("FAIL reset_out c%0d got=%b%b want=0",
                 i, busy, strobes());
      end
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b%b want=00", busy, done);
    end
  endtask

  task automatic test_minimal();
    int c, i, v, d, r;
    run("minimal", 1, 1, 0, 0, 1'b1, 1'b0, c, i, v, d, r);
    checks++;
    if (i != 1 || d != 1) begin
      errors++;
      $display("FAIL minimal_cnt got=ins%0d done%0d want=ins1 done1", i, d);
    end
  endtask

  task automatic test_no_insert();
    int c, i, v, d, r;
    run("no_insert", 1, 2, -1, 0, 1'b0, 1'b0, c, i, v, d, r);
    checks++;
    if (i != 0 || r != 2) begin
      errors++;
      $display("FAIL no_insert_cnt got=ins%0d rd%0d want=ins0 rd2", i, r);
    end
  endtask

  task automatic test_mid_insert();
    int c, i, v, d, r;
    run("mid_insert", 1, 1, 2, 0, 1'b0, 1'b0, c, i, v, d, r);
    checks++;
    if (i != 1) begin
      errors++;
      $display("FAIL mid_insert_cnt got=%0d want=1", i);
    end
  endtask

  task automatic test_multi();
    int c, i, v, d, r;
    run("multi", 3, 2, 1, 5, 1'b0, 1'b0, c, i, v, d, r);
    checks++;
    if (c != 3 || v != 3 || d != 1) begin
      errors++;
      $display("FAIL multi_cnt got=clr%0d vote%0d done%0d want=3 3 1",
               c, v, d);
    end
  endtask

  task automatic test_busy_start();
    int c, i, v, d, r;
    run("busy_start", 2, 1, 3, 1, 1'b0, 1'b1, c, i, v, d, r);
    checks++;
    if (c != 2 || d != 1) begin
      errors++;
      $display("FAIL busy_start_cnt got=clr%0d done%0d want=2 1", c, d);
    end
  endtask

  task automatic test_zero_counts();
    int c, i, v, d, r;
    run("n_test0", 0, 3, -1, 0, 1'b0, 1'b0, c, i, v, d, r);
    checks++;
    if (c != 0 || d != 1) begin
      errors++;
      $display("FAIL n_test0_cnt got=clr%0d done%0d want=0 1", c, d);
    end
    run("n_data0", 1, 0, -1, 0, 1'b0, 1'b0, c, i, v, d, r);
    checks++;
    if (r != 0 || c != 1 || v != 1) begin
      errors++;
      $display("FAIL n_data0_cnt got=rd%0d clr%0d vote%0d want=0 1 1",
               r, c, v);
    end
  endtask

  task automatic test_abort();
    int nd = 0;
    ins_s = -1;
    @(negedge clk);
    start = 1'b1;
    n_test = 6'd1;
    n_data = 10'd1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, strobes(), slot_idx, data_addr, test_addr} !== '0) begin
      errors++;
      $display("FAIL abort_idle got=busy%b stb%b slot%0d want=0",
               busy, strobes(), slot_idx);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      nd += int'(done) + int'(busy);
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_quiet got=%0d want=0", nd);
    end
  endtask

  initial begin
    test_reset();
    test_minimal();
    test_no_insert();
    test_mid_insert();
    test_multi();
    test_busy_start();
    test_zero_counts();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
